// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter fed by a small circular FIFO.
//
// Words are pushed over a valid/ready handshake, buffered, and sent as
// start bit, DATA_BITS data bits (LSB first), an optional parity bit and
// STOP_BITS stop bits. When another word is waiting at the end of a frame,
// its start bit follows immediately, so consecutive frames have no idle gap.
//
// Handshake: a word is accepted on every rising edge where data_valid and
// data_ready are both high. data_ready is simply !full, and a word is held
// off for as long as data_valid stays high while data_ready is low.
//
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous active-high reset; clears FIFO, FSM and line
//   data       - word to transmit (DATA_BITS wide)
//   data_valid - word present on data
//   data_ready - FIFO can accept a word (not full)
//   tx_line    - registered serial output, idles high
//   busy       - a frame is in progress (FSM not idle)
//   finish     - one-cycle pulse on the last cycle of a frame's final stop bit
//   fifo_count - words queued, not counting the frame being sent
//   state_dbg  - current FSM state encoding, for observation only
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 1,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_BITS-1:0]          data,
  input  logic                          data_valid,
  output logic                          data_ready,
  output logic                          tx_line,
  output logic                          busy,
  output logic                          finish,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [2:0]                    state_dbg
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);

  localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_ONE   = BW'(1);
  localparam logic [IW-1:0] BIT_LAST   = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] BIT_ONE    = IW'(1);
  localparam logic [AW:0]   FULL_COUNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   COUNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);
  localparam logic          STOP_LAST  = (STOP_BITS == 2);
  localparam logic          ODD        = (PARITY == 2);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // FIFO storage and pointers
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic                 push, load, empty;
  logic [DATA_BITS-1:0] head;

  // Transmit datapath
  state_t               state, state_n;
  logic [BW-1:0]        baud_cnt, baud_n;
  logic [IW-1:0]        bit_idx, bit_n;
  logic                 stop_cnt, stop_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 par_bit, par_n;
  logic                 tx_n;
  logic                 baud_tc;

  assign data_ready = (fifo_count != FULL_COUNT);
  assign empty      = (fifo_count == '0);
  assign push       = data_valid && data_ready;
  assign head       = mem[rd_ptr];
  assign busy       = (state != S_IDLE);
  assign state_dbg  = state;
  assign baud_tc    = (baud_cnt == BAUD_LAST);

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (load) rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, load})
        2'b10:   fifo_count <= fifo_count + COUNT_ONE;
        2'b01:   fifo_count <= fifo_count - COUNT_ONE;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Storage needs no reset: a flush is just the pointers and count clearing.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      stop_cnt <= 1'b0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      tx_line  <= 1'b1;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_n;
      bit_idx  <= bit_n;
      stop_cnt <= stop_n;
      shreg    <= shreg_n;
      par_bit  <= par_n;
      tx_line  <= tx_n;
    end
  end

  always_comb begin
    state_n = state;
    baud_n  = baud_tc ? '0 : baud_cnt + BAUD_ONE;
    bit_n   = bit_idx;
    stop_n  = stop_cnt;
    shreg_n = shreg;
    par_n   = par_bit;
    load    = 1'b0;
    finish  = 1'b0;

    case (state)
      S_IDLE: begin
        baud_n = '0;
        if (!empty) begin
          load    = 1'b1;
          state_n = S_START;
        end
      end
      S_START: begin
        if (baud_tc) begin
          state_n = S_DATA;
          bit_n   = '0;
        end
      end
      S_DATA: begin
        if (baud_tc) begin
          shreg_n = shreg >> 1;
          if (bit_idx == BIT_LAST) begin
            state_n = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_n = bit_idx + BIT_ONE;
          end
        end
      end
      S_PARITY: begin
        if (baud_tc) state_n = S_STOP;
      end
      S_STOP: begin
        if (baud_tc) begin
          if (stop_cnt == STOP_LAST) begin
            finish = 1'b1;
            // Chain straight into the next start bit when a word is waiting.
            if (!empty) begin
              load    = 1'b1;
              state_n = S_START;
            end else begin
              state_n = S_IDLE;
            end
          end else begin
            stop_n = stop_cnt + 1'b1;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase

    // A load captures the FIFO head and its parity, and restarts bit timing.
    if (load) begin
      shreg_n = head;
      par_n   = (^head) ^ ODD;
      baud_n  = '0;
      stop_n  = 1'b0;
    end

    // The line is registered, so it is driven from the state being entered.
    case (state_n)
      S_START:  tx_n = 1'b0;
      S_DATA:   tx_n = shreg_n[0];
      S_PARITY: tx_n = par_n;
      default:  tx_n = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo. Three instances share clock and reset:
//   dut_a : 8 data bits, even parity, 1 stop bit
//   dut_b : 8 data bits, odd parity, 1 stop bit
//   dut_c : 7 data bits, no parity, 2 stop bits
// All use 4 clocks per bit. Each pushed word appends its expected
// per-cycle {finish, tx_line} sequence to that instance's queue; once armed,
// the scoreboard pops one entry per cycle and compares it with the outputs.
module tb_uart_tx_fifo;

  localparam int CPB = 4;

  logic       clk;
  logic       rst;

  logic [7:0] data_a, data_b;
  logic [6:0] data_c;
  logic       valid_a, valid_b, valid_c;
  logic       ready_a, ready_b, ready_c;
  logic       tx_a, tx_b, tx_c;
  logic       busy_a, busy_b, busy_c;
  logic       fin_a, fin_b, fin_c;
  logic [2:0] cnt_a, cnt_b, cnt_c;
  logic [2:0] st_a, st_b, st_c;

  logic [1:0] exp_a[$];
  logic [1:0] exp_b[$];
  logic [1:0] exp_c[$];
  logic       go_a, go_b, go_c;

  int checks;
  int errors;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB)) dut_a (
    .clk(clk), .rst(rst), .data(data_a), .data_valid(valid_a),
    .data_ready(ready_a), .tx_line(tx_a), .busy(busy_a), .finish(fin_a),
    .fifo_count(cnt_a), .state_dbg(st_a)
  );

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .PARITY(2)) dut_b (
    .clk(clk), .rst(rst), .data(data_b), .data_valid(valid_b),
    .data_ready(ready_b), .tx_line(tx_b), .busy(busy_b), .finish(fin_b),
    .fifo_count(cnt_b), .state_dbg(st_b)
  );

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) dut_c (
    .clk(clk), .rst(rst), .data(data_c), .data_valid(valid_c),
    .data_ready(ready_c), .tx_line(tx_c), .busy(busy_c), .finish(fin_c),
    .fifo_count(cnt_c), .state_dbg(st_c)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [12:0] frame_vec(input int dbits, input int par, input logic [8:0] w);
    logic [12:0] v;
    logic        p;
    int          n;
    v = '1;
    p = 1'b0;
    v[0] = 1'b0;
    n = 1;
    for (int i = 0; i < dbits; i++) begin
      v[n] = w[i];
      p = p ^ w[i];
      n++;
    end
    if (par == 1) v[n] = p;
    if (par == 2) v[n] = ~p;
    return v;
  endfunction

  function automatic int frame_len(input int dbits, input int par, input int stops);
    return 1 + dbits + ((par != 0) ? 1 : 0) + stops;
  endfunction

  task automatic expect_a(input logic [7:0] w);
    logic [12:0] v;
    int n;
    v = frame_vec(8, 1, {1'b0, w});
    n = frame_len(8, 1, 1);
    for (int b = 0; b < n; b++)
      for (int c = 0; c < CPB; c++)
        exp_a.push_back({(b == n - 1) && (c == CPB - 1), v[b]});
  endtask

  task automatic expect_b(input logic [7:0] w);
    logic [12:0] v;
    int n;
    v = frame_vec(8, 2, {1'b0, w});
    n = frame_len(8, 2, 1);
    for (int b = 0; b < n; b++)
      for (int c = 0; c < CPB; c++)
        exp_b.push_back({(b == n - 1) && (c == CPB - 1), v[b]});
  endtask

  task automatic expect_c(input logic [6:0] w);
    logic [12:0] v;
    int n;
    v = frame_vec(7, 0, {2'b00, w});
    n = frame_len(7, 0, 2);
    for (int b = 0; b < n; b++)
      for (int c = 0; c < CPB; c++)
        exp_c.push_back({(b == n - 1) && (c == CPB - 1), v[b]});
  endtask

  // ---------------- scoreboard ----------------
  task automatic scoreboard();
    logic [1:0] e;
    forever begin
      @(negedge clk);
      if (go_a && exp_a.size() > 0) begin
        e = exp_a.pop_front();
        checks++;
        if ({fin_a, tx_a} !== e) begin
          errors++;
          $display("FAIL sb_a {finish,tx_line}: got %b expected %b at %0t", {fin_a, tx_a}, e, $time);
        end
      end
      if (go_b && exp_b.size() > 0) begin
        e = exp_b.pop_front();
        checks++;
        if ({fin_b, tx_b} !== e) begin
          errors++;
          $display("FAIL sb_b {finish,tx_line}: got %b expected %b at %0t", {fin_b, tx_b}, e, $time);
        end
      end
      if (go_c && exp_c.size() > 0) begin
        e = exp_c.pop_front();
        checks++;
        if ({fin_c, tx_c} !== e) begin
          errors++;
          $display("FAIL sb_c {finish,tx_line}: got %b expected %b at %0t", {fin_c, tx_c}, e, $time);
        end
      end
    end
  endtask

  function automatic int qsize(input int which);
    case (which)
      0:       return exp_a.size();
      1:       return exp_b.size();
      default: return exp_c.size();
    endcase
  endfunction

  function automatic logic fin_of(input int which);
    case (which)
      0:       return fin_a;
      1:       return fin_b;
      default: return fin_c;
    endcase
  endfunction

  // Waits (bounded) until a queue is consumed; reports cycles and finish pulses.
  task automatic wait_drain(input int which, input int bound, output int cyc, output int fins);
    cyc  = 0;
    fins = 0;
    while (qsize(which) > 0 && cyc < bound) begin
      @(negedge clk); #1;
      cyc++;
      if (fin_of(which)) fins++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({tx_a, busy_a, fin_a, ready_a, cnt_a} !== {1'b1, 1'b0, 1'b0, 1'b1, 3'd0}) begin
      errors++;
      $display("FAIL reset_a {tx,busy,finish,ready,count}: got %b expected 1001000",
               {tx_a, busy_a, fin_a, ready_a, cnt_a});
    end
    checks++;
    if ({tx_b, busy_b, tx_c, busy_c, ready_c} !== 5'b10101) begin
      errors++;
      $display("FAIL reset_bc {tx_b,busy_b,tx_c,busy_c,ready_c}: got %b expected 10101",
               {tx_b, busy_b, tx_c, busy_c, ready_c});
    end
    // Start a frame, then hit reset between clock edges.
    data_a  = 8'h5A;
    valid_a = 1'b1;
    @(posedge clk); #1;
    valid_a = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({busy_a, tx_a} !== 2'b10) begin
      errors++;
      $display("FAIL reset_pre {busy,tx}: got %b expected 10", {busy_a, tx_a});
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({tx_a, busy_a, fin_a, ready_a, cnt_a} !== {1'b1, 1'b0, 1'b0, 1'b1, 3'd0}) begin
      errors++;
      $display("FAIL reset_async {tx,busy,finish,ready,count}: got %b expected 1001000",
               {tx_a, busy_a, fin_a, ready_a, cnt_a});
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_even_parity();
    int n, f;
    @(negedge clk); #1;
    data_a  = 8'hA5;
    valid_a = 1'b1;
    expect_a(8'hA5);
    @(posedge clk); #1;
    valid_a = 1'b0;
    data_a  = 8'h00;
    @(negedge clk); #1;
    checks++;
    if ({tx_a, busy_a, cnt_a} !== {1'b1, 1'b0, 3'd1}) begin
      errors++;
      $display("FAIL even_pre_load {tx,busy,count}: got %b expected 10001", {tx_a, busy_a, cnt_a});
    end
    @(posedge clk); #1;
    go_a = 1'b1;
    @(negedge clk); #1;
    checks++;
    if ({busy_a, cnt_a} !== {1'b1, 3'd0}) begin
      errors++;
      $display("FAIL even_load {busy,count}: got %b expected 1000", {busy_a, cnt_a});
    end
    wait_drain(0, 200, n, f);
    checks++;
    if (n !== 43 || qsize(0) != 0) begin
      errors++;
      $display("FAIL even_len: got %0d remaining cycles (%0d left) expected 43", n, qsize(0));
    end
    checks++;
    if (f !== 1) begin
      errors++;
      $display("FAIL even_finish_count: got %0d expected 1", f);
    end
    @(negedge clk); #1;
    checks++;
    if ({busy_a, fin_a, tx_a} !== 3'b001) begin
      errors++;
      $display("FAIL even_idle {busy,finish,tx}: got %b expected 001", {busy_a, fin_a, tx_a});
    end
    go_a = 1'b0;
  endtask

  task automatic test_odd_parity();
    int n, f;
    @(negedge clk); #1;
    data_b  = 8'h00;
    valid_b = 1'b1;
    expect_b(8'h00);
    @(posedge clk); #1;
    data_b = 8'h07;
    expect_b(8'h07);
    @(posedge clk); #1;
    valid_b = 1'b0;
    data_b  = 8'hFF;
    go_b    = 1'b1;
    wait_drain(1, 300, n, f);
    checks++;
    if (n !== 88 || qsize(1) != 0) begin
      errors++;
      $display("FAIL odd_len: got %0d cycles (%0d left) expected 88", n, qsize(1));
    end
    checks++;
    if (f !== 2) begin
      errors++;
      $display("FAIL odd_finish_count: got %0d expected 2", f);
    end
    @(negedge clk); #1;
    checks++;
    if ({busy_b, tx_b, cnt_b} !== {1'b0, 1'b1, 3'd0}) begin
      errors++;
      $display("FAIL odd_idle {busy,tx,count}: got %b expected 01000", {busy_b, tx_b, cnt_b});
    end
    go_b = 1'b0;
  endtask

  task automatic test_fill_stream();
    int   idx, cyc, n, f, fins, maxc, push6_cyc, cnt_after2;
    logic ready5, pushing;
    idx = 0; cyc = -1; fins = 0; maxc = 0; push6_cyc = -1; cnt_after2 = -1; ready5 = 1'b1;
    while (idx < 6 && cyc < 300) begin
      @(negedge clk); #1;
      cyc++;
      if (fin_a) fins++;
      if (int'(cnt_a) > maxc) maxc = int'(cnt_a);
      if (cyc == 5) ready5 = ready_a;
      data_a  = 8'h11 + 8'(idx);
      valid_a = 1'b1;
      pushing = ready_a;
      if (pushing) begin
        expect_a(data_a);
        if (idx == 5) push6_cyc = cyc;
      end
      @(posedge clk); #1;
      if (pushing) idx++;
      if (cyc == 1) begin
        cnt_after2 = int'(cnt_a);
        go_a = 1'b1;
      end
    end
    valid_a = 1'b0;
    data_a  = 8'hEE;
    wait_drain(0, 400, n, f);
    fins += f;
    checks++;
    if (cnt_after2 !== 1) begin
      errors++;
      $display("FAIL fill_push_pop_count: got %0d expected 1", cnt_after2);
    end
    checks++;
    if (maxc !== 4 || ready5 !== 1'b0) begin
      errors++;
      $display("FAIL fill_full: got max count %0d ready %b expected 4 and 0", maxc, ready5);
    end
    checks++;
    if (push6_cyc !== 46) begin
      errors++;
      $display("FAIL fill_stall: got 6th push at cycle %0d expected 46", push6_cyc);
    end
    checks++;
    if (fins !== 6 || qsize(0) != 0) begin
      errors++;
      $display("FAIL fill_finish_count: got %0d (%0d left) expected 6", fins, qsize(0));
    end
    @(negedge clk); #1;
    checks++;
    if ({busy_a, cnt_a} !== {1'b0, 3'd0}) begin
      errors++;
      $display("FAIL fill_idle {busy,count}: got %b expected 0000", {busy_a, cnt_a});
    end
    go_a = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    int n, f, bad;
    @(negedge clk); #1;
    data_a  = 8'hC3;
    valid_a = 1'b1;
    expect_a(8'hC3);
    @(posedge clk); #1;
    data_a = 8'h3C;
    @(posedge clk); #1;
    go_a   = 1'b1;
    data_a = 8'h99;
    @(posedge clk); #1;
    valid_a = 1'b0;
    repeat (17) @(negedge clk);
    #1;
    checks++;
    if ({cnt_a, busy_a, st_a, tx_a} !== {3'd2, 1'b1, 3'd2, 1'b0}) begin
      errors++;
      $display("FAIL mid_pre {count,busy,state,tx}: got %b expected 01010100", {cnt_a, busy_a, st_a, tx_a});
    end
    go_a = 1'b0;
    exp_a.delete();
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({tx_a, busy_a, fin_a, ready_a, cnt_a} !== {1'b1, 1'b0, 1'b0, 1'b1, 3'd0}) begin
      errors++;
      $display("FAIL mid_reset {tx,busy,finish,ready,count}: got %b expected 1001000",
               {tx_a, busy_a, fin_a, ready_a, cnt_a});
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk); #1;
      if (fin_a || !tx_a || busy_a || cnt_a != 3'd0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL mid_quiet: got %0d active cycles after reset expected 0", bad);
    end
    // A fresh word afterwards goes out normally.
    data_a  = 8'h3C;
    valid_a = 1'b1;
    expect_a(8'h3C);
    @(posedge clk); #1;
    valid_a = 1'b0;
    @(posedge clk); #1;
    go_a = 1'b1;
    wait_drain(0, 200, n, f);
    checks++;
    if (n !== 44 || f !== 1 || qsize(0) != 0) begin
      errors++;
      $display("FAIL mid_fresh: got %0d cycles %0d finishes expected 44 and 1", n, f);
    end
    go_a = 1'b0;
  endtask

  task automatic test_format_variant();
    int n, f;
    @(negedge clk); #1;
    data_c  = 7'h55;
    valid_c = 1'b1;
    expect_c(7'h55);
    @(posedge clk); #1;
    valid_c = 1'b0;
    data_c  = 7'($urandom_range(0, 127));
    @(posedge clk); #1;
    go_c = 1'b1;
    wait_drain(2, 200, n, f);
    checks++;
    if (n !== 40 || qsize(2) != 0) begin
      errors++;
      $display("FAIL variant_len: got %0d cycles (%0d left) expected 40", n, qsize(2));
    end
    checks++;
    if (f !== 1) begin
      errors++;
      $display("FAIL variant_finish_count: got %0d expected 1", f);
    end
    @(negedge clk); #1;
    checks++;
    if ({busy_c, fin_c, tx_c} !== 3'b001) begin
      errors++;
      $display("FAIL variant_idle {busy,finish,tx}: got %b expected 001", {busy_c, fin_c, tx_c});
    end
    go_c = 1'b0;
  endtask

  // ---------------- main ----------------
  initial begin
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    data_a  = '0; data_b  = '0; data_c  = '0;
    valid_a = 1'b0; valid_b = 1'b0; valid_c = 1'b0;
    go_a    = 1'b0; go_b    = 1'b0; go_c    = 1'b0;
    fork
      scoreboard();
    join_none
    test_reset();
    test_even_parity();
    test_odd_parity();
    test_fill_stream();
    test_reset_mid_frame();
    test_format_variant();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter with an input FIFO, configurable frame format and a fixed baud divisor. It accepts words over a valid/ready handshake, buffers up to `FIFO_DEPTH` of them and serialises each one as start, data (LSB first), optional parity and 1 or 2 stop bits. Frames go out back-to-back with no idle gap. It replaces the single-shot button-triggered transmitter on the serial TX pin of the FPGA top level and is driven by the processor's memory-mapped I/O.

## Interface
- `CLKS_PER_BIT`, 5208 — clock cycles per bit (50 MHz / 9600 baud); must be ≥ 2.
- `DATA_BITS`, 8 — data bits per frame; range 5..9.
- `PARITY`, 1 — 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1 — 1 or 2.
- `FIFO_DEPTH`, 4 — FIFO entries; power of two, ≥ 2.
- `clk` input 1 — single clock, rising edge.
- `rst` input 1 — asynchronous, active-high reset; one clock; clears everything.
- `data` input `DATA_BITS` — word to transmit.
- `data_valid` input 1 — word present on `data`.
- `data_ready` output 1 — FIFO can accept; equals !full.
- `tx_line` output 1 — serial line, idles high, registered.
- `busy` output 1 — a frame is in progress (FSM not in IDLE).
- `finish` output 1 — one-cycle pulse on the last cycle of each frame's final stop bit.
- `fifo_count` output $clog2(FIFO_DEPTH)+1 — words queued, not counting the frame in flight.

## Operation
- **Push:** a push happens on any edge where `data_valid` and `data_ready` are both high. A push while full is impossible because `data_ready` = 0; a held `data_valid` is simply stalled.
- **FIFO:** circular buffer with read/write pointers that wrap modulo `FIFO_DEPTH`.
  - Push and pop in the same cycle: both take effect and `fifo_count` is unchanged.
  - Full: `fifo_count` == `FIFO_DEPTH`.
- **Load:** pops the FIFO head into the shift register and latches the parity bit.
  - Even parity = XOR of the data bits; odd parity = its inverse.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
  - **IDLE:** `tx_line` = 1. If the FIFO is not empty: load, clear the baud counter, go to START.
  - **START:** `tx_line` = 0 for `CLKS_PER_BIT` cycles, then go to DATA with the bit index = 0.
  - **DATA:** `tx_line` = shift register bit 0. Each bit is held `CLKS_PER_BIT` cycles, then the register shifts right and the index increments.
    - After bit `DATA_BITS`-1: go to PARITY, or to STOP if `PARITY` = 0.
  - **PARITY:** `tx_line` = latched parity bit for `CLKS_PER_BIT` cycles, then go to STOP.
  - **STOP:** `tx_line` = 1 for `STOP_BITS`×`CLKS_PER_BIT` cycles. On the last cycle, `finish` = 1.
    - If the FIFO is not empty at that edge: load and enter START directly, with no IDLE cycle.
    - Otherwise: go to IDLE.
- **Baud counter:** counts 0..`CLKS_PER_BIT`-1 and wraps. Its terminal count advances the bit or state.
  - A separate stop-bit counter handles `STOP_BITS` = 2.
- **Changing `data`** after a push has no effect on queued or in-flight words.
- **Reset at any time**, including mid-frame:
  - `tx_line` = 1, `busy` = 0, `finish` = 0, `data_ready` = 1, `fifo_count` = 0.
  - State = IDLE, FIFO flushed, counters = 0.
  - The partial frame is abandoned; the line simply returns high.

## Timing
- **Latency:** for a push at edge E into an empty FIFO with the FSM in IDLE:
  - the load happens at E+1;
  - `tx_line` is low and `busy` is high from E+1.
- **Frame length:** (1 + `DATA_BITS` + (`PARITY` ≠ 0) + `STOP_BITS`) × `CLKS_PER_BIT` cycles, exactly.
- **Back-to-back frames:** the next start bit begins on the cycle after the previous frame's `finish` pulse.
- **`fifo_count`:** decrements on the load edge and increments on the push edge, both registered.
- **`busy`:** falls on the edge after `finish` only if the FIFO is empty.
- **Idle:** `finish` never asserts while IDLE.

## Test plan
All directed tests use `CLKS_PER_BIT` = 4.

1. **Reset:** assert `rst` asynchronously between edges.
   - Outputs go immediately to `tx_line` = 1, `busy` = 0, `finish` = 0, `data_ready` = 1, `fifo_count` = 0.
2. **Even parity, 0xA5** (defaults: 8 bits, even, 1 stop); push one word.
   - `tx_line` sequence, 4 cycles per bit: 0, 1,0,1,0,0,1,0,1, parity 0, stop 1.
   - `finish` pulses on cycle 44 after the load; `busy` drops the next cycle.
3. **Odd parity, 0x00** (`PARITY` = 2).
   - Parity bit = 1.
   - 0x07 gives parity bit = 0 (three ones, odd already).
4. **Fill and stream** (`FIFO_DEPTH` = 4): push 0x11..0x16 with `data_valid` held high.
   - First word is loaded at once; `fifo_count` reaches 4; `data_ready` = 0 stalls the 6th word until the first pop.
   - All 6 frames are contiguous (66×4 = 264 cycles), with 6 `finish` pulses.
   - Push and pop in the same cycle leave the count stable.
5. **Reset mid-frame:** assert `rst` during the DATA bit 3 of a frame, with 2 words queued.
   - Line goes high, FIFO is empty, and no `finish` pulse occurs.
   - A fresh push afterwards transmits correctly.
6. **Format variant:** `DATA_BITS` = 7, `PARITY` = 0, `STOP_BITS` = 2; push 0x55.
   - Sequence: 0, 1,0,1,0,1,0,1, 1, 1.
   - Frame = 40 cycles; `finish` pulses on the last cycle of the second stop bit.
